// File: rtl/ofmap_drain_pkg.sv
// Shared types and constants for the ofmap drain stage.
// Holds the beat-count helper, serializer states and the drained-vector counter width.
package ofmap_drain_pkg;

    // Drained-vector counter spans the 2048-entry output memory address space.
    localparam int unsigned VecCountW = 11;

    typedef enum logic [0:0] {
        Idle,
        Send
    } serState_e;

    function automatic int unsigned calcBeats(input int unsigned psumBw,
                                              input int unsigned col,
                                              input int unsigned outBw);
        return (psumBw * col) / outBw;
    endfunction

endpackage

// File: rtl/ofmap_drain_vec_fifo.sv
// Register-based vector FIFO: depth entries of width bits, head visible at the read pointer.
// Clear has priority over push and pop.
module vec_fifo #(
    parameter int unsigned depth = 4,
    parameter int unsigned width = 128,
    localparam int unsigned PtrW = (depth > 1) ? $clog2(depth) : 1,
    localparam int unsigned LevelW = PtrW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic [width-1:0]  pushData,
    input  logic              pop,
    output logic [width-1:0]  headData,
    output logic [LevelW-1:0] level,
    output logic              empty,
    output logic              full
);

    logic [width-1:0]  mem [depth];
    logic [PtrW-1:0]   wrPtr;
    logic [PtrW-1:0]   rdPtr;
    logic [LevelW-1:0] levelNext;

    always_comb begin
        levelNext = level;
        if (clear) begin
            levelNext = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   levelNext = level + LevelW'(1);
                2'b01:   levelNext = level - LevelW'(1);
                default: levelNext = level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            level <= levelNext;
            if (clear) begin
                wrPtr <= '0;
                rdPtr <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + PtrW'(1);
                if (pop)  rdPtr <= rdPtr + PtrW'(1);
            end
        end
    end

    // Storage carries no reset; consumers gate the head while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wrPtr] <= pushData;
    end

    assign headData = mem[rdPtr];
    assign empty    = (level == '0);
    assign full     = (level == LevelW'(depth));

endmodule

// File: rtl/ofmap_drain.sv
// Drains core output vectors through a small FIFO and serializes them into out_bw-bit beats.
// Counts drained vectors and flags vectors dropped while the FIFO is full.
module ofmap_drain
    import ofmap_drain_pkg::*;
#(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned out_bw  = 32,
    parameter int unsigned depth   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     valid,
    input  logic [psum_bw*col-1:0]   coreOut,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [out_bw-1:0]        out_data,
    output logic                     out_last,
    output logic [VecCountW-1:0]     vec_count,
    output logic                     overflow,
    output logic                     fifo_empty,
    output logic                     fifo_full
);

    localparam int unsigned Beats  = calcBeats(psum_bw, col, out_bw);
    localparam int unsigned VecW   = psum_bw * col;
    localparam int unsigned BeatW  = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned LevelW = ((depth > 1) ? $clog2(depth) : 1) + 1;

    serState_e         state, stateNext;
    logic [BeatW-1:0]  beatIdx, beatIdxNext;
    logic [VecW-1:0]   headData;
    logic [LevelW-1:0] level;
    logic              handshake, lastBeat, finalHs, room, push, pop;

    assign handshake = (state == Send) && out_ready;
    assign lastBeat  = (beatIdx == BeatW'(Beats - 1));
    assign finalHs   = handshake && lastBeat;
    // A final-beat pop frees a slot in the same cycle, so a push at full still fits.
    assign room      = !fifo_full || finalHs;
    assign push      = valid && room && !clear;
    assign pop       = finalHs && !clear;

    vec_fifo #(
        .depth (depth),
        .width (VecW)
    ) u_vec_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .push     (push),
        .pushData (coreOut),
        .pop      (pop),
        .headData (headData),
        .level    (level),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_comb begin
        stateNext   = state;
        beatIdxNext = beatIdx;
        if (clear) begin
            stateNext   = Idle;
            beatIdxNext = '0;
        end else begin
            unique case (state)
                Idle: begin
                    if (push) stateNext = Send;
                end
                Send: begin
                    if (handshake) begin
                        if (lastBeat) begin
                            beatIdxNext = '0;
                            if (level == LevelW'(1) && !push) stateNext = Idle;
                        end else begin
                            beatIdxNext = beatIdx + BeatW'(1);
                        end
                    end
                end
                default: stateNext = Idle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= Idle;
            beatIdx   <= '0;
            vec_count <= '0;
            overflow  <= 1'b0;
        end else begin
            state   <= stateNext;
            beatIdx <= beatIdxNext;
            if (clear) begin
                vec_count <= '0;
                overflow  <= 1'b0;
            end else begin
                if (pop) vec_count <= vec_count + VecCountW'(1);
                if (valid && !room) overflow <= 1'b1;
            end
        end
    end

    assign out_valid = (state == Send);
    assign out_last  = out_valid && lastBeat;
    assign out_data  = out_valid ? headData[int'(beatIdx) * out_bw +: out_bw] : '0;

endmodule

// File: tb/tb_ofmap_drain.sv
// Randomized and directed bench for ofmap_drain with a queue-based reference model.
// Expected beats go into a scoreboard queue; a monitor pops and compares on each handshake.
`timescale 1ns/1ps
module tb_ofmap_drain;

    localparam int W  = 128;
    localparam int OB = 32;
    localparam int B  = 4;
    localparam int D  = 4;

    typedef struct {
        logic [OB-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          valid = 1'b0;
    logic [W-1:0]  coreOut = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [OB-1:0] out_data;
    logic          out_last;
    logic [10:0]   vec_count;
    logic          overflow;
    logic          fifo_empty;
    logic          fifo_full;

    int passed = 0;
    int total  = 0;

    // Reference model: stored vectors, beat position of the head, drained count, sticky drop flag.
    logic [W-1:0] vq[$];
    beat_t        expq[$];
    int           mbeat  = 0;
    int           mcount = 0;
    bit           movf   = 1'b0;

    ofmap_drain #(
        .col     (8),
        .psum_bw (16),
        .out_bw  (OB),
        .depth   (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .valid      (valid),
        .coreOut    (coreOut),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .vec_count  (vec_count),
        .overflow   (overflow),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic modelFlush();
        vq.delete();
        expq.delete();
        mbeat  = 0;
        mcount = 0;
        movf   = 1'b0;
    endtask

    task automatic checkStatus();
        check("out_valid", out_valid, vq.size() > 0);
        check("vec_count", vec_count, mcount % 2048);
        check("overflow", overflow, movf);
        check("fifo_empty", fifo_empty, vq.size() == 0);
        check("fifo_full", fifo_full, vq.size() == D);
        if (vq.size() == 0) begin
            check("idle out_data", out_data, 0);
            check("idle out_last", out_last, 0);
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic rdy, input logic clr);
        bit    hs, fin, room;
        beat_t b;
        @(negedge clk);
        valid     = v;
        coreOut   = d;
        out_ready = rdy;
        clear     = clr;
        if (clr) begin
            modelFlush();
        end else begin
            hs   = (vq.size() > 0) && rdy;
            fin  = hs && (mbeat == B - 1);
            room = (vq.size() < D) || fin;
            if (hs) begin
                if (fin) begin
                    void'(vq.pop_front());
                    mbeat = 0;
                    mcount++;
                end else begin
                    mbeat++;
                end
            end
            if (v) begin
                if (room) begin
                    vq.push_back(d);
                    for (int k = 0; k < B; k++) begin
                        b.data = d[k*OB +: OB];
                        b.last = (k == B - 1);
                        expq.push_back(b);
                    end
                end else begin
                    movf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        checkStatus();
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        valid = 1'b0;
        clear = 1'b0;
        modelFlush();
        #1;
        checkStatus();
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_last", out_last, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [W-1:0] rndVec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: consumes one expected beat per handshake and checks stall stability.
    logic          prevStall = 1'b0;
    logic [OB-1:0] prevData  = '0;
    logic          prevLast  = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        #2;
        if (reset && !clear && out_valid) begin
            if (prevStall) begin
                check("stall data stable", out_data, prevData);
                check("stall last stable", out_last, prevLast);
            end
            if (out_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    $display("FAIL unexpected beat: got %0h, expected no beat at %0t",
                             out_data, $time);
                end else begin
                    e = expq.pop_front();
                    check("beat data", out_data, e.data);
                    check("beat last", out_last, e.last);
                end
            end
        end
        prevStall = reset && !clear && out_valid && !out_ready;
        prevData  = out_data;
        prevLast  = out_last;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] v0;
        for (int i = 0; i < 8; i++) v0[i*16 +: 16] = 16'(i);

        #3;
        checkStatus();
        check("reset out_data", out_data, 0);
        @(negedge clk);
        reset = 1'b1;

        // Single vector, ready held high.
        step(1, v0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, '0, 1, 0);

        // Back-pressure 1,0,0,1,... mid-vector.
        step(1, rndVec(), 0, 0);
        for (int i = 0; i < 14; i++) step(0, '0, (i % 3) == 0, 0);

        // Overflow: five pushes with ready low, then drain.
        for (int i = 0; i < 5; i++) step(1, rndVec(), 0, 0);
        for (int i = 0; i < 20; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 1);

        // Push at full coinciding with a final-beat pop.
        for (int i = 0; i < 4; i++) step(1, rndVec(), 0, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
        step(1, rndVec(), 1, 0);
        check("push at final pop keeps level", fifo_full, 1);
        check("push at final pop no overflow", overflow, 0);
        for (int i = 0; i < 20; i++) step(0, '0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(($urandom % 3) == 0, rndVec(), ($urandom % 4) != 0, ($urandom % 97) == 0);
        for (int i = 0; i < 24; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 1);

        // Counter wrap: 2049 vectors at the full beat rate.
        for (int i = 0; i < 2049 * B; i++) step((i % B) == 0, rndVec(), 1, 0);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
        check("vec_count wrap", vec_count, 1);

        // Clear after two beats, then async reset after two beats of the next vector.
        step(1, rndVec(), 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 1);
        check("clear fifo_empty", fifo_empty, 1);
        check("clear vec_count", vec_count, 0);
        step(1, rndVec(), 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        doReset();
        check("reset fifo_empty", fifo_empty, 1);
        step(1, v0, 1, 0);
        check("restart beat 0", out_data, 32'h0001_0000);
        for (int i = 0; i < 6; i++) step(0, '0, 1, 0);
        check("scoreboard drained", expq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
